// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU operation sequencer: state encoding,
// error codes, op bit positions and the one-hot legality check.
package fpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_ENCODE = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_ABORT   = 2'b11;

    localparam int OP_ROUND = 0;
    localparam int OP_SQRT  = 1;
    localparam int OP_ADD   = 2;
    localparam int OP_SUB   = 3;
    localparam int OP_MULT  = 4;
    localparam int OP_DIV   = 5;
    localparam int OP_COMP  = 6;

    // Widest op vector the legality check handles; callers zero-extend into it.
    localparam int MAX_OPS = 32;

    function automatic logic is_onehot(input logic [MAX_OPS-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/fpu_seq_timer.sv
// Per-phase watchdog: counts enabled cycles since the last clear and flags
// when the count reaches TIMEOUT_CYC-1.
module fpu_seq_timer #(
    parameter int TIMEOUT_W   = 8,
    parameter int TIMEOUT_CYC = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);

    logic [TIMEOUT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/fpu_sequencer.sv
// FPU operation sequencer: walks one op through decoder, selected unit and
// encoder, waiting on each ready under a watchdog, and reports done or error.
module fpu_sequencer
    import fpu_pkg::*;
#(
    parameter int NUM_OPS     = 7,
    parameter int TIMEOUT_W   = 8,
    parameter int TIMEOUT_CYC = 200
) (
    input  logic               fpu_clk,
    input  logic               fpu_rst_n,
    input  logic               fpu_en_i,
    input  logic               fpu_start_i,
    input  logic [NUM_OPS-1:0] fpu_op_i,
    input  logic               fpu_dec_ready_i,
    input  logic [NUM_OPS-1:0] fpu_mod_ready_i,
    input  logic               fpu_enc_ready_i,
    output logic               fpu_dec_en_o,
    output logic [NUM_OPS-1:0] fpu_mod_en_o,
    output logic               fpu_enc_en_o,
    output logic               fpu_busy_o,
    output logic               fpu_done_o,
    output logic               fpu_err_o,
    output logic [1:0]         fpu_err_code_o
);

    state_t               state;
    state_t               state_next;
    state_t               advance;
    logic [NUM_OPS-1:0]   op_q;
    logic [1:0]           err_code_q;
    logic [1:0]           err_code_next;
    logic                 busy;
    logic                 accept;
    logic                 waited_ready;
    logic                 timer_expired;

    assign busy   = (state == ST_DECODE) || (state == ST_EXEC) || (state == ST_ENCODE);
    assign accept = (state == ST_IDLE) && fpu_en_i && fpu_start_i
                    && is_onehot(MAX_OPS'(fpu_op_i));

    // NOTE: every signal written here gets a default first so no path through
    // the case statement leaves it unassigned and infers a latch.
    always_comb begin
        state_next    = state;
        err_code_next = err_code_q;
        advance       = ST_IDLE;
        waited_ready  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (fpu_en_i && fpu_start_i) begin
                    if (accept) begin
                        state_next    = ST_DECODE;
                        err_code_next = ERR_NONE;
                    end else begin
                        state_next    = ST_ERROR;
                        err_code_next = ERR_ILLEGAL;
                    end
                end
            end
            ST_DECODE: begin
                waited_ready = fpu_dec_ready_i;
                advance      = ST_EXEC;
            end
            ST_EXEC: begin
                waited_ready = |(fpu_mod_ready_i & op_q);
                advance      = ST_ENCODE;
            end
            ST_ENCODE: begin
                waited_ready = fpu_enc_ready_i;
                advance      = ST_DONE;
            end
            ST_DONE, ST_ERROR: state_next = ST_IDLE;
            default:           state_next = ST_IDLE;
        endcase

        // Abort beats ready, and ready on the expiry cycle still wins over timeout.
        if (busy) begin
            if (!fpu_en_i) begin
                state_next    = ST_ERROR;
                err_code_next = ERR_ABORT;
            end else if (waited_ready) begin
                state_next    = advance;
            end else if (timer_expired) begin
                state_next    = ST_ERROR;
                err_code_next = ERR_TIMEOUT;
            end
        end
    end

    // NOTE: only control registers sit behind the asynchronous reset; there is
    // no storage array here that would need to stay out of it.
    always_ff @(posedge fpu_clk or negedge fpu_rst_n) begin
        if (!fpu_rst_n) begin
            state      <= ST_IDLE;
            op_q       <= '0;
            err_code_q <= ERR_NONE;
        end else begin
            state      <= state_next;
            err_code_q <= err_code_next;
            if (accept) begin
                op_q <= fpu_op_i;
            end
        end
    end

    fpu_seq_timer #(
        .TIMEOUT_W   (TIMEOUT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk     (fpu_clk),
        .rst_n   (fpu_rst_n),
        .clear   (state_next != state),
        .enable  (busy),
        .expired (timer_expired)
    );

    // Outputs decode registered state only, so they drop with reset at once.
    always_comb begin
        fpu_dec_en_o   = busy;
        fpu_mod_en_o   = ((state == ST_EXEC) || (state == ST_ENCODE)) ? op_q : '0;
        fpu_enc_en_o   = (state == ST_ENCODE);
        fpu_busy_o     = busy;
        fpu_done_o     = (state == ST_DONE);
        fpu_err_o      = (state == ST_ERROR);
        fpu_err_code_o = err_code_q;
    end

endmodule

// File: tb/tb_fpu_sequencer.sv
// Directed bench for fpu_sequencer: expected outcomes are queued when an op is
// started and compared when the done or error pulse appears.
module tb_fpu_sequencer;

    localparam int NUM_OPS = 7;

    typedef struct packed {
        logic       done;
        logic [1:0] code;
    } result_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               en;
    logic               start;
    logic [NUM_OPS-1:0] op;
    logic               dec_ready;
    logic [NUM_OPS-1:0] mod_ready;
    logic               enc_ready;
    logic               dec_en;
    logic [NUM_OPS-1:0] mod_en;
    logic               enc_en;
    logic               busy;
    logic               done;
    logic               err;
    logic [1:0]         err_code;

    result_t sb[$];
    int      checks = 0;
    int      errors = 0;

    always #5 clk = ~clk;

    fpu_sequencer #(
        .NUM_OPS     (NUM_OPS),
        .TIMEOUT_W   (8),
        .TIMEOUT_CYC (200)
    ) dut (
        .fpu_clk         (clk),
        .fpu_rst_n       (rst_n),
        .fpu_en_i        (en),
        .fpu_start_i     (start),
        .fpu_op_i        (op),
        .fpu_dec_ready_i (dec_ready),
        .fpu_mod_ready_i (mod_ready),
        .fpu_enc_ready_i (enc_ready),
        .fpu_dec_en_o    (dec_en),
        .fpu_mod_en_o    (mod_en),
        .fpu_enc_en_o    (enc_en),
        .fpu_busy_o      (busy),
        .fpu_done_o      (done),
        .fpu_err_o       (err),
        .fpu_err_code_o  (err_code)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic start_op(input logic [NUM_OPS-1:0] o, input logic exp_done,
                            input logic [1:0] exp_code);
        result_t r;
        r.done = exp_done;
        r.code = exp_code;
        sb.push_back(r);
        en    = 1'b1;
        start = 1'b1;
        op    = o;
        step();
        start = 1'b0;
    endtask

    task automatic wait_result(input string tag, input int budget);
        result_t r;
        int      n = 0;
        while (!(done || err) && n < budget) begin
            step();
            n++;
        end
        check({tag, "_seen"}, 32'(done || err), 32'd1);
        if ((done || err) && sb.size() > 0) begin
            r = sb.pop_front();
            check({tag, "_done"}, 32'(done), 32'(r.done));
            check({tag, "_err"},  32'(err),  32'(!r.done));
            check({tag, "_code"}, 32'(err_code), 32'(r.code));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n     = 1'b1;
        en        = 1'b0;
        start     = 1'b0;
        op        = '0;
        dec_ready = 1'b0;
        mod_ready = '0;
        enc_ready = 1'b0;
        #1 rst_n  = 1'b0;
        repeat (2) step();
        check("reset_outputs", 32'({dec_en, mod_en, enc_en, busy, done, err, err_code}), 32'd0);
        rst_n = 1'b1;
        step();

        // 1: ADD with each ready one cycle after its enable
        start_op(7'b0000100, 1'b1, 2'b00);
        check("t1_decode", 32'({dec_en, mod_en, enc_en, busy}), 32'b1_0000000_0_1);
        step();
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
        check("t1_exec_mod_en", 32'(mod_en), 32'b0000100);
        check("t1_exec_enc_en", 32'(enc_en), 32'd0);
        step();
        mod_ready = 7'b0000100;
        step();
        mod_ready = '0;
        check("t1_encode", 32'({mod_en, enc_en}), 32'b0000100_1);
        step();
        enc_ready = 1'b1;
        step();
        enc_ready = 1'b0;
        wait_result("t1", 4);
        check("t1_done_enables", 32'({dec_en, mod_en, enc_en, busy}), 32'd0);
        step();
        check("t1_done_pulse", 32'(done), 32'd0);

        // 2: two bits set, then zero bits set -> illegal op
        start_op(7'b0000110, 1'b0, 2'b01);
        check("t2_no_enables", 32'({dec_en, mod_en, enc_en, busy}), 32'd0);
        wait_result("t2", 2);
        step();
        check("t2_err_pulse", 32'(err), 32'd0);
        check("t2_code_hold", 32'(err_code), 32'b01);
        start_op(7'b0000000, 1'b0, 2'b01);
        wait_result("t2z", 2);
        step();

        // 3: MULT with only an unselected unit ready -> timeout in EXEC
        dec_ready = 1'b1;
        mod_ready = 7'b0000100;
        start_op(7'b0010000, 1'b0, 2'b10);
        step();
        check("t3_mod_en", 32'(mod_en), 32'b0010000);
        n = 0;
        while (mod_en == 7'b0010000 && n < 1000) begin
            n++;
            step();
        end
        check("t3_exec_cycles", 32'(n), 32'd200);
        wait_result("t3", 2);
        check("t3_enables_drop", 32'({dec_en, mod_en, enc_en, busy}), 32'd0);
        mod_ready = '0;
        step();

        // 3b: ready on the expiry cycle counts as ready
        start_op(7'b0000001, 1'b1, 2'b00);
        step();
        repeat (199) step();
        mod_ready = 7'b0000001;
        step();
        mod_ready = '0;
        check("t3b_encode", 32'({enc_en, err}), 32'b10);
        enc_ready = 1'b1;
        wait_result("t3b", 4);
        enc_ready = 1'b0;
        step();

        // 4: abort in ENCODE beats a simultaneous enc_ready, then a clean rerun
        dec_ready = 1'b1;
        mod_ready = 7'h7f;
        start_op(7'b1000000, 1'b0, 2'b11);
        step();
        step();
        check("t4_in_encode", 32'(enc_en), 32'd1);
        en        = 1'b0;
        enc_ready = 1'b1;
        step();
        check("t4_abort_enables", 32'({dec_en, mod_en, enc_en, busy}), 32'd0);
        wait_result("t4", 1);
        en = 1'b1;
        step();
        start_op(7'b0001000, 1'b1, 2'b00);
        check("t4_code_cleared", 32'({busy, err_code}), 32'b1_00);
        n = 1;
        while (!done && n < 20) begin
            step();
            n++;
        end
        check("t4_latency", 32'(n), 32'd4);
        wait_result("t4r", 1);
        step();

        // 5: reset while in EXEC drops everything without waiting for a clock
        mod_ready = '0;
        enc_ready = 1'b0;
        start_op(7'b0000010, 1'b1, 2'b00);
        step();
        check("t5_exec", 32'(mod_en), 32'b0000010);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_reset", 32'({dec_en, mod_en, enc_en, busy, done, err, err_code}), 32'd0);
        sb.delete();
        step();
        rst_n = 1'b1;
        repeat (3) step();
        check("t5_idle_after", 32'({dec_en, mod_en, enc_en, busy, done, err}), 32'd0);

        // 6: back-to-back ops; start and op changes while busy are ignored
        mod_ready = 7'h7f;
        enc_ready = 1'b1;
        start_op(7'b0000100, 1'b1, 2'b00);
        wait_result("t6a", 6);
        step();
        start_op(7'b0100000, 1'b1, 2'b00);
        check("t6_second_busy", 32'(busy), 32'd1);
        start = 1'b1;
        op    = 7'b0000011;
        step();
        start = 1'b0;
        check("t6_op_held", 32'(mod_en), 32'b0100000);
        wait_result("t6b", 6);
        step();
        check("t6_idle", 32'({busy, done, err}), 32'd0);
        check("t6_sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
